// File: rtl/fp16_pkg.sv
// Shared fp16 format constants and pipeline payload types for the relaxed add/sub datapath.
// FP16_RADDSUB_ROUND_EN adds guard/sticky fields to the normalized payload for round-to-nearest-even.
package fp16_pkg;

    localparam int unsigned FP16_W        = 16;
    localparam int unsigned FP16_EXP_W    = 5;
    localparam int unsigned FP16_FRAC_W   = 10;
    localparam int unsigned FP16_EXP_BIAS = 15;
    localparam int unsigned FP16_EXP_MAX  = 31;
    localparam int unsigned RAW_MANT_W    = 21;
    localparam int unsigned LZC_W         = 5;
    localparam int unsigned KEPT_W        = FP16_FRAC_W + 1;
    localparam int unsigned LOST_W        = RAW_MANT_W - KEPT_W;

    localparam logic [FP16_W-1:0] FP16_POS_INF = 16'h7C00;

    typedef struct packed {
        logic                  sign;
        logic [FP16_EXP_W-1:0] exp;
        logic [RAW_MANT_W-1:0] mant;
    } fp16_raw_t;

    // Normalized beat held between the shift stage and the round/pack stage.
    typedef struct packed {
        logic                  sign;
        logic [FP16_EXP_W-1:0] ex;
        logic [KEPT_W-1:0]     kept;
`ifdef FP16_RADDSUB_ROUND_EN
        logic                  guard;
        logic                  sticky;
`endif
    } fp16_norm_t;

endpackage

// File: rtl/fp16_lzc21.sv
// Combinational leading-zero counter for the 21-bit raw magnitude; all-zero input returns 21.
module fp16_lzc21
    import fp16_pkg::*;
(
    input  logic [RAW_MANT_W-1:0] value,
    output logic [LZC_W-1:0]      count
);

    // Scan upward so the highest set bit determines the final count.
    always_comb begin
        count = LZC_W'(RAW_MANT_W);
        for (int i = 0; i < int'(RAW_MANT_W); i++) begin
            if (value[i]) begin
                count = LZC_W'(int'(RAW_MANT_W) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp16_raddsub_norm.sv
// Normalize/round/pack back end of the fp16 add/sub pipe: 2-stage elastic valid/ready pipeline.
// Build option FP16_RADDSUB_ROUND_EN selects round-to-nearest-even; otherwise the result is truncated.
module fp16_raddsub_norm
    import fp16_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [FP16_EXP_W-1:0] in_exp,
    input  logic [RAW_MANT_W-1:0] in_mant,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FP16_W-1:0]     out_data
);

    localparam int unsigned SUM_W  = KEPT_W + 1;
    localparam int unsigned EXPC_W = FP16_EXP_W + 1;

    fp16_raw_t             raw_c;
    fp16_norm_t            norm_c;
    fp16_norm_t            s1_q;
    logic                  s1_v;
    logic [LZC_W-1:0]      lz_c;
    logic [FP16_EXP_W-1:0] e_c;
    logic [FP16_EXP_W-1:0] sh_lim_c;
    logic [FP16_EXP_W-1:0] sh_c;
    logic                  rnd_c;
    logic [SUM_W-1:0]      sum_c;
    logic [EXPC_W-1:0]     ex_c;
    logic [FP16_W-1:0]     pack_c;
    logic                  s2_adv_c;
    logic                  accept_c;
`ifdef FP16_RADDSUB_ROUND_EN
    logic [LOST_W-1:0]     lost_c;
`endif

    assign raw_c = '{sign: in_sign, exp: in_exp, mant: in_mant};

    fp16_lzc21 u_lzc (
        .value (raw_c.mant),
        .count (lz_c)
    );

    // Stage 1: shift out leading zeros, but never below the subnormal scale (exponent 1).
    always_comb begin
        norm_c   = '0;
        e_c      = (raw_c.exp == '0) ? FP16_EXP_W'(1) : raw_c.exp;
        sh_lim_c = e_c - FP16_EXP_W'(1);
        sh_c     = (FP16_EXP_W'(lz_c) < sh_lim_c) ? FP16_EXP_W'(lz_c) : sh_lim_c;
        // Cancellation to zero always yields +0.
        norm_c.sign = raw_c.sign & (|raw_c.mant);
        norm_c.kept = KEPT_W'(RAW_MANT_W'(raw_c.mant << sh_c) >> LOST_W);
`ifdef FP16_RADDSUB_ROUND_EN
        lost_c        = LOST_W'(raw_c.mant << sh_c);
        norm_c.guard  = lost_c[LOST_W-1];
        norm_c.sticky = |lost_c[LOST_W-2:0];
`endif
        norm_c.ex = norm_c.kept[KEPT_W-1] ? (e_c - sh_c) : '0;
    end

    // Stage 2: round, fix up carry-out / subnormal promotion, saturate to infinity, pack.
    always_comb begin
`ifdef FP16_RADDSUB_ROUND_EN
        rnd_c = s1_q.guard & (s1_q.sticky | s1_q.kept[0]);
`else
        rnd_c = 1'b0;
`endif
        sum_c = {1'b0, s1_q.kept} + SUM_W'(rnd_c);
        ex_c  = {1'b0, s1_q.ex};
        if (sum_c[KEPT_W]) begin
            ex_c = ex_c + EXPC_W'(1);
        end else if ((s1_q.ex == '0) && sum_c[KEPT_W-1]) begin
            ex_c = EXPC_W'(1);
        end
        if (ex_c >= EXPC_W'(FP16_EXP_MAX)) begin
            pack_c = {s1_q.sign, FP16_POS_INF[FP16_W-2:0]};
        end else begin
            pack_c = {s1_q.sign, ex_c[FP16_EXP_W-1:0], sum_c[FP16_FRAC_W-1:0]};
        end
    end

    assign s2_adv_c = ~out_valid | out_ready;
    assign in_ready = ~rst & (~s1_v | s2_adv_c);
    assign accept_c = in_valid & in_ready;

    // Pipe registers: S1 refills on accept, output stage advances whenever it is empty or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_q      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (accept_c) begin
                s1_v <= 1'b1;
                s1_q <= norm_c;
            end else if (s2_adv_c) begin
                s1_v <= 1'b0;
            end
            if (s2_adv_c) begin
                out_valid <= s1_v;
                if (s1_v) begin
                    out_data <= pack_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp16_raddsub_norm.sv
// Self-checking bench for fp16_raddsub_norm: directed vectors, random traffic against a value-level model,
// back-pressure and reset flush. Honors FP16_RADDSUB_ROUND_EN like the design.
module tb_fp16_raddsub_norm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [4:0]  in_exp = '0;
    logic [20:0] in_mant = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp16_raddsub_norm dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Value-level reference: scale up by 2 while the exponent allows, then round on the integer quotient.
    function automatic logic [15:0] model(input logic s, input logic [4:0] x, input logic [20:0] mt);
        int e, m, ex, kept, rem;
        bit up;
        if (mt == 0) return 16'h0000;
        e = (x == 0) ? 1 : int'(x);
        m = int'(mt);
        while (m < (1 << 20) && e > 1) begin
            m = m * 2;
            e = e - 1;
        end
        ex   = (m >= (1 << 20)) ? e : 0;
        kept = m / 1024;
        rem  = m % 1024;
`ifdef FP16_RADDSUB_ROUND_EN
        up = (rem > 512) || (rem == 512 && (kept % 2) == 1);
`else
        up = 1'b0;
`endif
        kept = kept + int'(up);
        if (kept == 2048) begin
            kept = 1024;
            ex   = ex + 1;
        end
        if (ex == 0 && kept >= 1024) ex = 1;
        if (ex >= 31) return {s, 15'h7C00};
        return {s, 5'(ex), 10'(kept % 1024)};
    endfunction

    // Set inputs at the falling edge; outputs are sampled 1 time unit later, well before the rising edge.
    task automatic drive(input logic v, input logic s, input logic [4:0] x, input logic [20:0] mt,
                         input logic r);
        @(negedge clk);
        in_valid  = v;
        in_sign   = s;
        in_exp    = x;
        in_mant   = mt;
        out_ready = r;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 5'd15, 21'h100000, 1'b1);
        drive(1'b1, 1'b0, 5'd15, 21'h100000, 1'b1);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out_data: got %h want 0000", out_data);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 21'h0, 1'b1);
    endtask

    typedef struct packed {
        logic        s;
        logic [4:0]  x;
        logic [20:0] m;
        logic [15:0] e;
    } vec_t;

    task automatic test_directed();
        vec_t tab[11];
        int   lat;
        tab[0] = '{1'b0, 5'd15, 21'h000000, 16'h0000};
        tab[1] = '{1'b1, 5'd15, 21'h000000, 16'h0000};
        tab[2] = '{1'b0, 5'd15, 21'h040000, 16'h3400};
        tab[3] = '{1'b0, 5'd15, 21'h100200, 16'h3C00};
        tab[4] = '{1'b0, 5'd2,  21'h020000, 16'h0100};
        tab[5] = '{1'b1, 5'd15, 21'h100000, 16'hBC00};
        tab[6] = '{1'b0, 5'd31, 21'h100000, 16'h7C00};
`ifdef FP16_RADDSUB_ROUND_EN
        tab[7] = '{1'b0, 5'd15, 21'h100600, 16'h3C02};
        tab[8] = '{1'b0, 5'd30, 21'h1FFE00, 16'h7C00};
        tab[9] = '{1'b0, 5'd0,  21'h0FFE00, 16'h0400};
`else
        tab[7] = '{1'b0, 5'd15, 21'h100600, 16'h3C01};
        tab[8] = '{1'b0, 5'd30, 21'h1FFE00, 16'h7BFF};
        tab[9] = '{1'b0, 5'd0,  21'h0FFE00, 16'h03FF};
`endif
        tab[10] = '{1'b0, 5'd0, 21'h000001, 16'h0000};
        foreach (tab[i]) begin
            drive(1'b1, tab[i].s, tab[i].x, tab[i].m, 1'b1);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready);
            end
            lat = 0;
            do begin
                drive(1'b0, 1'b0, 5'd0, 21'h0, 1'b1);
                lat++;
            end while (out_valid !== 1'b1 && lat < 10);
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d want 2", i, lat);
            end
            checks++;
            if (out_data !== tab[i].e) begin
                errors++;
                $display("FAIL dir%0d_data: got %h want %h", i, out_data, tab[i].e);
            end
        end
        drive(1'b0, 1'b0, 5'd0, 21'h0, 1'b1);
    endtask

    task automatic test_random(input int n);
        logic [15:0] q[$];
        logic [15:0] exp_d, prev_data;
        logic        v, r, s, prev_stall;
        logic [4:0]  x;
        logic [20:0] mt;
        int          sent, cyc;
        sent = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        while ((sent < n || q.size() > 0) && cyc < 20000) begin
            v  = (sent < n) && ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) != 0);
            s  = 1'($urandom);
            x  = 5'($urandom_range(0, 30));
            mt = 21'($urandom) >> $urandom_range(0, 21);
            drive(v, s, x, mt, r);
            cyc++;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL rand_hold: got v=%b d=%h want v=1 d=%h", out_valid, out_data, prev_data);
                end
            end
            if (r) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_in_ready: got %b want 1 with out_ready high", in_ready);
                end
            end
            if (v && in_ready) begin
                q.push_back(model(s, x, mt));
                sent++;
            end
            if (out_valid && r) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: got %h want no output", out_data);
                end else begin
                    exp_d = q.pop_front();
                    if (out_data !== exp_d) begin
                        errors++;
                        $display("FAIL rand_data: got %h want %h", out_data, exp_d);
                    end
                end
            end
            prev_stall = out_valid && !r;
            prev_data  = out_data;
        end
        checks++;
        if (sent != n || q.size() != 0) begin
            errors++;
            $display("FAIL rand_timeout: got sent=%0d pending=%0d want sent=%0d pending=0", sent, q.size(), n);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q[$];
        logic [15:0] exp_d, prev_data;
        logic        v, r, prev_stall, saw_block;
        logic [4:0]  x;
        logic [20:0] mt;
        int          sent, got, cyc;
        sent = 0;
        got = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        saw_block = 1'b0;
        while ((sent < 4 || q.size() > 0) && cyc < 50) begin
            v  = (sent < 4);
            r  = !(cyc >= 2 && cyc <= 4);
            x  = 5'(10 + sent);
            mt = 21'h100000 | 21'(sent * 21'h00A5F3);
            drive(v, 1'b0, x, mt, r);
            if (v && !in_ready) saw_block = 1'b1;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL b2b_hold: got v=%b d=%h want v=1 d=%h", out_valid, out_data, prev_data);
                end
            end
            if (v && in_ready) begin
                q.push_back(model(1'b0, x, mt));
                sent++;
            end
            if (out_valid && r) begin
                got++;
                checks++;
                exp_d = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
                if (out_data !== exp_d) begin
                    errors++;
                    $display("FAIL b2b_data: got %h want %h", out_data, exp_d);
                end
            end
            prev_stall = out_valid && !r;
            prev_data  = out_data;
            cyc++;
        end
        checks++;
        if (saw_block !== 1'b1) begin
            errors++;
            $display("FAIL b2b_backpressure: got in_ready never low want a low cycle");
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d results want 4", got);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b0, 5'd15, 21'h123456, 1'b0);
        drive(1'b1, 1'b1, 5'd20, 21'h1ABCDE, 1'b0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        drive(1'b0, 1'b0, 5'd0, 21'h0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_out_valid: got %b want 0", out_valid);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 5'd0, 21'h0, 1'b1);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_leak: got out_valid=%b data=%h want nothing", out_valid, out_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(300);
        test_back_to_back();
        test_flush();
        test_random(100);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
